// File: rtl/ysyx_23060184_axi_rd_slave.sv
// AXI4 read-only slave bridging AR/R bursts onto a simple synchronous memory
// port (one-cycle read latency), with programmable pre-access wait cycles.
module ysyx_23060184_axi_rd_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  // AR channel
  input  logic [DATA_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  // R channel
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic                  rlast,
  // memory port
  output logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    CAPT,
    RESP
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                state;
  logic [DATA_WIDTH-1:0] addr;
  logic [ID_WIDTH-1:0]   id;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic                  err;
  logic [7:0]            beat_cnt;
  logic [3:0]            wait_cnt;
  logic                  capt_wait;

  logic                  ar_err;
  logic [DATA_WIDTH-1:0] next_addr;
  logic                  last_beat;

  // Unsupported burst type, oversize beat or misaligned start address.
  always_comb begin
    ar_err = 1'b0;
    if (arburst[1] || (arsize > 3'd2)) begin
      ar_err = 1'b1;
    end else begin
      case (arsize)
        3'd1:    ar_err = araddr[0];
        3'd2:    ar_err = |araddr[1:0];
        default: ar_err = 1'b0;
      endcase
    end
  end

  always_comb begin
    next_addr = addr;
    if (burst == BURST_INCR) begin
      next_addr = addr + (DATA_WIDTH'(1) << size);
    end
  end

  assign last_beat = (beat_cnt == len);

  // NOTE: every register below is assigned with <= so all updates in a cycle
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      rid       <= '0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      addr      <= '0;
      id        <= '0;
      len       <= '0;
      size      <= '0;
      burst     <= '0;
      err       <= 1'b0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      capt_wait <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid) begin
            addr     <= araddr;
            id       <= arid;
            len      <= arlen;
            size     <= arsize;
            burst    <= arburst;
            err      <= ar_err;
            beat_cnt <= '0;
            wait_cnt <= 4'(LATENCY);
            arready  <= 1'b0;
            state    <= (LATENCY > 0) ? WAIT : READ;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= READ;
          end
        end

        // The strobe is registered here, so memory sees it during the first
        // CAPT cycle and returns data in the second one.
        READ: begin
          mem_ren   <= !err;
          mem_raddr <= {addr[DATA_WIDTH-1:2], 2'b00};
          capt_wait <= 1'b1;
          state     <= CAPT;
        end

        CAPT: begin
          mem_ren <= 1'b0;
          if (capt_wait) begin
            capt_wait <= 1'b0;
          end else begin
            rdata  <= err ? '0 : mem_rdata;
            rresp  <= err ? RESP_SLVERR : RESP_OKAY;
            rid    <= id;
            rlast  <= last_beat;
            rvalid <= 1'b1;
            state  <= RESP;
          end
        end

        RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (last_beat) begin
              arready <= 1'b1;
              state   <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              addr     <= next_addr;
              state    <= READ;
            end
          end
        end

        default: begin
          arready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_axi_rd_slave.sv
// Directed bench for the AXI read slave: table of bursts plus hand-written
// backpressure and mid-burst reset sequences against a one-cycle memory model.
module tb_ysyx_23060184_axi_rd_slave;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic        rlast;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ren_total = 0;
  logic [31:0] ren_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    bit          err;
    int          n_ren;
  } vec_t;

  vec_t vecs[8];

  ysyx_23060184_axi_rd_slave #(
    .DATA_WIDTH(32),
    .ID_WIDTH  (4),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .arid     (arid),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .rid      (rid),
    .rlast    (rlast),
    .mem_ren  (mem_ren),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8000_0004) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // Synchronous memory: data appears the cycle after the strobe is sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ren) begin
      mem_rdata <= mem_word(mem_raddr);
      ren_q.push_back(mem_raddr);
      ren_total <= ren_total + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input vec_t v, input int b);
    logic [31:0] a;
    a = v.addr;
    if (v.burst == 2'b01) a = v.addr + 32'(b) * (32'd1 << v.size);
    return a & ~32'd3;
  endfunction

  task automatic issue_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] bu, input logic [3:0] i, output int hs);
    int n;
    n = 0;
    @(negedge clk);
    araddr = a; arlen = l; arsize = s; arburst = bu; arid = i; arvalid = 1'b1;
    while (!arready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ar_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    hs = cyc;
  endtask

  task automatic wait_rvalid(input string name, output bit ok);
    int n;
    n = 0;
    while (!rvalid && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = rvalid;
    if (!ok) check({name, "_rvalid_timeout"}, 32'(rvalid), 32'd1);
  endtask

  task automatic run_burst(input int idx, input vec_t v);
    int hs, base_cnt, base_q;
    bit ok;
    logic [31:0] ea;
    string tag;
    tag = $sformatf("v%0d", idx);
    rready = 1'b1;
    base_cnt = ren_total;
    base_q = ren_q.size();
    issue_ar(v.addr, v.len, v.size, v.burst, v.id, hs);
    for (int b = 0; b <= int'(v.len); b++) begin
      wait_rvalid(tag, ok);
      if (!ok) return;
      if (b == 0) check({tag, "_first_latency"}, 32'(cyc - hs), 32'(LAT + 3));
      ea = exp_addr(v, b);
      check($sformatf("%s_rdata_b%0d", tag, b), rdata, v.err ? 32'd0 : mem_word(ea));
      check($sformatf("%s_rresp_b%0d", tag, b), 32'(rresp), v.err ? 32'd2 : 32'd0);
      check($sformatf("%s_rid_b%0d", tag, b), 32'(rid), 32'(v.id));
      check($sformatf("%s_rlast_b%0d", tag, b), 32'(rlast), 32'(b == int'(v.len)));
      @(negedge clk);
    end
    check({tag, "_arready_after_last"}, 32'(arready), 32'd1);
    check({tag, "_rvalid_after_last"}, 32'(rvalid), 32'd0);
    check({tag, "_mem_ren_count"}, 32'(ren_total - base_cnt), 32'(v.n_ren));
    for (int i = 0; i < v.n_ren && base_q + i < ren_q.size(); i++)
      check($sformatf("%s_mem_raddr_%0d", tag, i), ren_q[base_q + i], exp_addr(v, i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs, base_cnt, seen;
    bit ok;

    //            addr          len   size  burst  id    err   n_ren
    vecs[0] = '{32'h8000_0004, 8'd0, 3'd2, 2'b01, 4'd3, 1'b0, 1};
    vecs[1] = '{32'h8000_0000, 8'd3, 3'd2, 2'b01, 4'd1, 1'b0, 4};
    vecs[2] = '{32'h8000_0010, 8'd2, 3'd2, 2'b00, 4'd2, 1'b0, 3};
    vecs[3] = '{32'h8000_0000, 8'd1, 3'd2, 2'b10, 4'd4, 1'b1, 0};
    vecs[4] = '{32'h8000_0002, 8'd0, 3'd2, 2'b01, 4'd6, 1'b1, 0};
    vecs[5] = '{32'h8000_0001, 8'd3, 3'd0, 2'b01, 4'd7, 1'b0, 4};
    vecs[6] = '{32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'd8, 1'b1, 0};
    vecs[7] = '{32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 4'd9, 1'b0, 2};

    resetn = 1'b0; arvalid = 1'b0; rready = 1'b0;
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_mem_raddr", mem_raddr, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_burst(i, vecs[i]);

    // Backpressure on a single beat, with a competing AR held during RESP.
    rready = 1'b0;
    base_cnt = ren_total;
    issue_ar(32'h8000_0004, 8'd0, 3'd2, 2'b01, 4'd3, hs);
    wait_rvalid("bp", ok);
    if (ok) begin
      araddr = 32'h8000_0020; arid = 4'hA; arlen = 8'd0; arvalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("bp_rvalid_%0d", k), 32'(rvalid), 32'd1);
        check($sformatf("bp_rdata_%0d", k), rdata, 32'hDEAD_BEEF);
        check($sformatf("bp_rlast_%0d", k), 32'(rlast), 32'd1);
        check($sformatf("bp_arready_%0d", k), 32'(arready), 32'd0);
      end
      arvalid = 1'b0;
      rready = 1'b1;
      @(negedge clk);
      check("bp_rvalid_done", 32'(rvalid), 32'd0);
      check("bp_arready_done", 32'(arready), 32'd1);
      check("bp_mem_ren_count", 32'(ren_total - base_cnt), 32'd1);
    end

    // Asynchronous reset while beat 1 of a 4-beat burst waits in RESP.
    rready = 1'b0;
    issue_ar(32'h8000_0000, 8'd3, 3'd2, 2'b01, 4'd1, hs);
    wait_rvalid("rst_b0", ok);
    if (ok) begin
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      wait_rvalid("rst_b1", ok);
      if (ok) begin
        check("rst_mid_rdata_b1", rdata, mem_word(32'h8000_0004));
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_rlast", 32'(rlast), 32'd0);
        check("rst_mid_arready", 32'(arready), 32'd1);
        check("rst_mid_mem_ren", 32'(mem_ren), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rready = 1'b1;
        base_cnt = ren_total;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (rvalid) seen++;
        end
        check("rst_mid_no_beats", 32'(seen), 32'd0);
        check("rst_mid_no_mem_ren", 32'(ren_total - base_cnt), 32'd0);
      end
    end
    run_burst(8, '{32'h8000_0008, 8'd0, 3'd2, 2'b01, 4'd5, 1'b0, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_axi_rd_slave.md
YSYX_23060184_AXI_RD_SLAVE -- requirements
Module: ysyx_23060184_axi_rd_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning address/data width.
REQ-002 SHALL have parameter ID_WIDTH, default 4, meaning AXI ID width.
REQ-003 SHALL have parameter LATENCY, default 2, range 0-15, meaning wait cycles between AR acceptance and the first memory read.
REQ-004 SHALL have ports:
- clk  in  1  clock; single clock domain.
- resetn  in  1  reset; asynchronous, active-low.
- araddr  in  DATA_WIDTH  read address.
- arvalid  in  1  address valid.
- arready  out  1  address ready.
- arid  in  ID_WIDTH  transaction ID.
- arlen  in  8  beats minus one.
- arsize  in  3  bytes per beat, log2.
- arburst  in  2  burst type.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  response: 00 OKAY, 10 SLVERR.
- rvalid  out  1  data valid.
- rready  in  1  data ready.
- rid  out  ID_WIDTH  echoed arid.
- rlast  out  1  final beat.
- mem_ren  out  1  memory read strobe.
- mem_raddr  out  DATA_WIDTH  word-aligned memory address.
- mem_rdata  in  DATA_WIDTH  memory data; valid the cycle after mem_ren.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, READ, CAPT, RESP.
REQ-006 SHALL drive arready=1 only in IDLE; one outstanding transaction; no AR acceptance before the last R beat completes.
REQ-007 On arvalid&&arready at an edge, SHALL latch araddr, arid, arlen, arsize, arburst, and load the beat counter to 0 and the wait counter to LATENCY.
- Next state: WAIT if LATENCY>0, else READ.
REQ-008 In WAIT, SHALL decrement the wait counter each cycle and enter READ in the cycle after the counter reaches 1.
REQ-009 In READ, SHALL assert mem_ren=1 for exactly one cycle, with mem_raddr = current address with bits[1:0] cleared; next state CAPT.
REQ-010 In CAPT, SHALL register mem_rdata into rdata; next state RESP.
REQ-011 First rvalid SHALL be high exactly LATENCY+3 cycles after the AR handshake edge, i.e. the 3rd edge when LATENCY=0.
REQ-012 In RESP, SHALL hold rvalid=1, with rdata, rresp, rid, rlast stable until rready=1 at an edge.
REQ-013 On R handshake with beat counter < latched arlen:
- increment the beat counter;
- advance the address;
- enter READ; no LATENCY wait between beats.
REQ-014 On R handshake with beat counter == latched arlen, SHALL enter IDLE; arready returns high the next cycle.
REQ-015 rlast SHALL be 1 exactly when rvalid=1 and beat counter == latched arlen.
REQ-016 Address advance rules:
- INCR (01): add (1<<arsize) modulo 2^DATA_WIDTH.
- FIXED (00): address unchanged.
REQ-017 An error burst SHALL be any one of:
- arburst of 10 or 11;
- arsize > 2;
- address not aligned to arsize at the AR handshake.
REQ-018 For an error burst, SHALL return arlen+1 beats with rresp=10, rdata=0, normal timing and rlast, and SHALL never assert mem_ren.
REQ-019 For narrow transfers, rdata SHALL carry the full aligned word; byte-lane selection is the master's responsibility.
REQ-020 rid SHALL equal the latched arid on every beat.
REQ-021 If arvalid is high in RESP, it SHALL be ignored; it is accepted only after return to IDLE.

Reset
REQ-022 resetn=0 SHALL immediately and asynchronously force:
- state IDLE;
- arready=1, rvalid=0, rlast=0, rdata=0, rresp=00, rid=0;
- mem_ren=0, mem_raddr=0;
- all counters and latched fields to 0.
REQ-023 Reset mid-burst SHALL abandon the burst with no further R beats; after resetn rises, the next AR SHALL be accepted normally.

Verification
REQ-024 Single read, LATENCY=2: araddr=0x80000004, arlen=0, arsize=2, arburst=01, arid=3, mem word 0xDEADBEEF -> mem_ren one cycle at 0x80000004; rvalid at handshake+5; rdata=0xDEADBEEF, rresp=00, rid=3, rlast=1.
REQ-025 INCR burst: arlen=3, araddr=0x80000000, rready=1 -> mem_raddr sequence 0x80000000/04/08/0C; rlast only on the 4th beat; arready high the cycle after the 4th beat.
REQ-026 Backpressure: rready=0 for 4 cycles during beat 0 -> rvalid, rdata, rlast stable all 4 cycles; no extra mem_ren.
REQ-027 Errors:
- arburst=10 with arlen=1 -> 2 beats, rresp=10, rdata=0, zero mem_ren.
- araddr=0x80000002 with arsize=2 -> 1 beat, rresp=10.
REQ-028 FIXED burst, arlen=2, araddr=0x80000010 -> three mem_ren all at 0x80000010.
REQ-029 Async reset asserted in RESP of beat 1 of 4 -> rvalid low with no clock edge; post-reset AR with arid=5 completes with rid=5.
